// File: rtl/product_accumulator_if.sv
// Product-in / frame-sum-out stream bundle for product_accumulator.
// master drives products and out_ready; slave is the accumulator.
interface product_accumulator_if #(
  parameter int PW    = 14,
  parameter int ACC_W = 17
);
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT multiplier products per frame; result valid the cycle after the COUNT-th accept.
// in_ready is registered and held low while a finished frame waits on out_ready.
module product_accumulator #(
  parameter int PW    = 14,
  parameter int COUNT = 8,
  parameter int ACC_W = 17
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  clear,
  product_accumulator_if.slave bus
);
  localparam int CW = $clog2(COUNT);

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [ACC_W-1:0] out_sum_q, out_sum_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ovf_acc, ovf_acc_n;
  logic             out_ovf_q, out_ovf_n;
  logic             out_valid_q, out_valid_n;
  logic             in_ready_q, in_ready_n;
  logic [ACC_W:0]   sum_ext;
  logic             accept;
  logic             last_beat;

  // One extra bit captures the carry out of the accumulator's MSB.
  assign sum_ext   = {1'b0, acc} + {{(ACC_W + 1 - PW){1'b0}}, bus.in_product};
  assign accept    = bus.in_valid && in_ready_q;
  assign last_beat = (cnt == CW'(COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACC;
      acc         <= '0;
      cnt         <= '0;
      ovf_acc     <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      ovf_acc     <= ovf_acc_n;
      out_sum_q   <= out_sum_n;
      out_ovf_q   <= out_ovf_n;
      out_valid_q <= out_valid_n;
      in_ready_q  <= in_ready_n;
    end
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    ovf_acc_n   = ovf_acc;
    out_sum_n   = out_sum_q;
    out_ovf_n   = out_ovf_q;
    out_valid_n = out_valid_q;
    in_ready_n  = in_ready_q;

    if (clear) begin
      // Abort wins over any beat or handshake; the last result stays on out_sum/out_ovf.
      state_n     = ACC;
      acc_n       = '0;
      cnt_n       = '0;
      ovf_acc_n   = 1'b0;
      out_valid_n = 1'b0;
      in_ready_n  = 1'b1;
    end else begin
      case (state)
        ACC: begin
          in_ready_n = 1'b1;
          if (accept) begin
            if (last_beat) begin
              out_sum_n   = sum_ext[ACC_W-1:0];
              out_ovf_n   = ovf_acc | sum_ext[ACC_W];
              out_valid_n = 1'b1;
              in_ready_n  = 1'b0;
              acc_n       = '0;
              cnt_n       = '0;
              ovf_acc_n   = 1'b0;
              state_n     = HOLD;
            end else begin
              acc_n     = sum_ext[ACC_W-1:0];
              ovf_acc_n = ovf_acc | sum_ext[ACC_W];
              cnt_n     = cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_n = 1'b0;
            in_ready_n  = 1'b1;
            state_n     = ACC;
          end
        end
        default: state_n = ACC;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage directly downstream of the constant multiplier (k × 119, 7-bit operand, 14-bit product). It accepts one product per valid/ready beat and sums COUNT consecutive products into a frame. It presents the frame sum on a valid/ready output, with a sticky overflow flag. It converts the combinational multiplier output into a registered, flow-controlled result stream.

## Interface
- PW, 14: product width; matches the multiplier result width. Maximum product is 127 × 119 = 15113.
- COUNT, 8: products per frame; legal range is COUNT ≥ 2.
- ACC_W, 17: accumulator and output width. The default, PW + clog2(COUNT), is overflow-free.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous frame abort.
- in_valid  input  1  in_product is valid.
- in_ready  output  1  stage accepts a product this cycle.
- in_product  input  PW  unsigned product from the multiplier.
- out_valid  output  1  out_sum / out_ovf hold a completed frame.
- out_ready  input  1  consumer accepts the frame.
- out_sum  output  ACC_W  frame sum, modulo 2^ACC_W.
- out_ovf  output  1  a carry left bit ACC_W-1 during the frame.

## Operation
- Two states:
  - ACC: in_ready = 1, accumulating.
  - HOLD: frame result presented, in_ready = 0.
- Internal registers:
  - acc (ACC_W bits)
  - cnt (clog2(COUNT) bits)
  - ovf_acc (sticky carry)
- Accept occurs when in_valid && in_ready.
- On accept with cnt < COUNT-1:
  - acc ← acc + zero-extended in_product, truncated to ACC_W bits.
  - ovf_acc ← ovf_acc | carry-out.
  - cnt ← cnt + 1.
- On accept with cnt == COUNT-1:
  - out_sum ← acc + in_product.
  - out_ovf ← ovf_acc | carry-out.
  - out_valid ← 1, in_ready ← 0.
  - acc, cnt, ovf_acc ← 0.
  - State → HOLD.
- HOLD, when out_valid && out_ready:
  - out_valid ← 0, in_ready ← 1.
  - State → ACC.
  - out_sum and out_ovf keep their last value.
- In HOLD, in_valid is ignored; no product is consumed.
- While out_valid = 1 and out_ready = 0, out_sum and out_ovf are held bit-stable.
- clear = 1 has priority over all non-reset activity:
  - acc, cnt, ovf_acc ← 0; out_valid ← 0; in_ready ← 1; state → ACC.
  - Any beat presented in the same cycle is discarded.
  - out_sum and out_ovf are unchanged.
- in_ready is a register, never derived combinationally from out_ready or in_valid.

## Timing
- While rst_n = 0, all outputs are 0:
  - in_ready = 0, out_valid = 0, out_sum = 0, out_ovf = 0.
  - state = ACC, acc = 0, cnt = 0.
- First rising edge after rst_n deasserts: in_ready → 1.
- rst_n assertion mid-frame or mid-HOLD clears everything immediately, without waiting for a clock edge; the partial frame is lost.
- Latency: out_valid rises on the edge that accepts the COUNT-th beat, and is visible the following cycle.
- Handshake on the output completes in HOLD at edge E; in_ready is 1 from the cycle after E.
- Minimum frame period is COUNT + 1 cycles: COUNT accept cycles plus one HOLD cycle, with out_ready tied high.
- Gaps in in_valid stall accumulation without loss; cnt holds.
- Simultaneous clear and the COUNT-th beat: clear wins; no frame is emitted.
- Simultaneous clear and an out_ready handshake in HOLD: the result is the same as clear alone, and the frame is treated as consumed.

## Test plan
- Reset:
  - Stimulus: hold rst_n low for 3 cycles with in_valid = 1.
  - Response: all outputs are 0 throughout; in_ready = 1 after the first edge following release; no beat is accepted while rst_n = 0.
- Basic frame (defaults, out_ready = 1):
  - Stimulus: products for k = 1..8 (119, 238, …, 952), one per cycle.
  - Response: out_valid = 1 for one cycle; out_sum = 4284; out_ovf = 0; in_ready = 0 for exactly that cycle.
- Worst-case magnitude:
  - Stimulus: 8 beats of 15113.
  - Response at ACC_W = 17: out_sum = 120904, out_ovf = 0.
  - Response at ACC_W = 14: out_sum = 6216, out_ovf = 1.
- Backpressure:
  - Stimulus: complete a frame; hold out_ready = 0 for 5 cycles while driving in_valid = 1 with 500; then assert out_ready.
  - Response: out_sum is stable; in_ready = 0 for all 5 cycles; no beat is counted; in_ready = 1 the cycle after the handshake; the next frame starts from 0.
- Sparse input:
  - Stimulus: 8 beats of 119, with in_valid deasserted for 0–3 random cycles between beats.
  - Response: out_sum = 952, asserted exactly after the 8th accepted beat.
- Abort and reset mid-frame:
  - Stimulus: 3 beats of 15113, then clear; then 8 beats of 119.
  - Response: out_sum = 952.
  - Stimulus: repeat with an asynchronous rst_n pulse (between clock edges) after beat 5.
  - Response: outputs drop to 0 immediately; the next full frame sums only post-reset beats.
